syscall_read_string: RTL and testbench

SYSCALL_READ_STRING -- requirements
Module: syscall_read_string

---
 rtl/syscall_read_string_pkg.sv | 16 +
 rtl/syscall_read_string_byte_packer.sv | 43 ++++
 rtl/syscall_read_string.sv | 134 +++++++++++++
 tb/tb_syscall_read_string.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/syscall_read_string_pkg.sv
// Shared definitions for the read-string syscall service: FSM states,
// syscall service codes and the console line terminator.
package syscall_read_string_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RECV  = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [31:0] SYS_READ_STRING  = 32'd8;
  localparam logic [31:0] SYS_PRINT_STRING = 32'd4;
  localparam logic [7:0]  NEWLINE          = 8'h0A;

endpackage

// File: rtl/syscall_read_string_byte_packer.sv
// Little-endian byte-to-word packer: collects bytes into lanes 0..3 and
// keeps unused lanes zero so the current word doubles as a padded flush word.
module byte_packer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        push,
  input  logic [7:0]  din,
  output logic [31:0] word,
  output logic [31:0] merged,
  output logic        full
);

  logic [31:0] buf_q;
  logic [1:0]  lane_q;

  always_comb begin
    merged = buf_q;
    merged[{lane_q, 3'b000} +: 8] = din;
    full = (lane_q == 2'd3);
    word = buf_q;
  end

  // A push into lane 3 hands the merged word to the writer and restarts empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_q  <= '0;
      lane_q <= '0;
    end else if (clr) begin
      buf_q  <= '0;
      lane_q <= '0;
    end else if (push) begin
      if (full) begin
        buf_q  <= '0;
        lane_q <= '0;
      end else begin
        buf_q  <= merged;
        lane_q <= lane_q + 2'd1;
      end
    end
  end

endmodule

// File: rtl/syscall_read_string.sv
// Read-string syscall ($v0==8): streams console bytes into word memory.
// Optional SYSCALL_ECHO_EN adds a registered echo of every accepted byte.
module syscall_read_string
  import syscall_read_string_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sys,
  input  logic [31:0] regv,
  input  logic [31:0] rega,
  input  logic [31:0] regb,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        busy,
  output logic        done
`ifdef SYSCALL_ECHO_EN
  ,
  output logic        echo_valid,
  output logic [7:0]  echo_data
`endif
);

  state_t      state, state_nx;
  logic        sys_q;
  logic [31:0] addr_q, len_q, cnt_q, cnt_nx;
  logic        start, accept, is_nl, store, flush_now;
  logic [31:0] pk_word, pk_merged;
  logic        pk_full;

  assign start     = (state == ST_IDLE) && sys && !sys_q && (regv == SYS_READ_STRING);
  assign accept    = (state == ST_RECV) && in_valid;
  assign is_nl     = (in_data == NEWLINE);
  assign store     = accept && !is_nl;
  assign cnt_nx    = cnt_q + 32'd1;
  assign flush_now = (state == ST_FLUSH);

  byte_packer u_packer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (start || flush_now),
    .push   (store),
    .din    (in_data),
    .word   (pk_word),
    .merged (pk_merged),
    .full   (pk_full)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    in_ready = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          if (regb == 32'd0)      state_nx = ST_DONE;
          else if (regb == 32'd1) state_nx = ST_FLUSH;
          else                    state_nx = ST_RECV;
        end
      end
      ST_RECV: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (accept && (is_nl || cnt_nx == len_q - 32'd1)) state_nx = ST_FLUSH;
      end
      ST_FLUSH: begin
        busy     = 1'b1;
        state_nx = ST_DONE;
      end
      ST_DONE: begin
        done     = 1'b1;
        state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // Lane-3 writes and the flush write never coincide: FLUSH accepts no bytes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sys_q     <= 1'b0;
      addr_q    <= '0;
      len_q     <= '0;
      cnt_q     <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      sys_q  <= sys;
      mem_we <= 1'b0;
      if (start) begin
        addr_q <= rega;
        len_q  <= regb;
        cnt_q  <= '0;
      end
      if (store) begin
        cnt_q <= cnt_nx;
        if (pk_full) begin
          mem_we    <= 1'b1;
          mem_addr  <= addr_q;
          mem_wdata <= pk_merged;
          addr_q    <= addr_q + 32'd1;
        end
      end
      if (flush_now) begin
        mem_we    <= 1'b1;
        mem_addr  <= addr_q;
        mem_wdata <= pk_word;
      end
    end
  end

`ifdef SYSCALL_ECHO_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      echo_valid <= 1'b0;
      echo_data  <= '0;
    end else begin
      echo_valid <= accept;
      if (accept) echo_data <= in_data;
    end
  end
`endif

endmodule

// File: tb/tb_syscall_read_string.sv
// Scoreboard bench for syscall_read_string: directed scenarios plus random strings.
module tb_syscall_read_string;
  import syscall_read_string_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n, sys, in_valid;
  logic [31:0] regv, rega, regb;
  logic [7:0]  in_data;
  logic        in_ready, mem_we, busy, done;
  logic [31:0] mem_addr, mem_wdata;

  always #5 clk = ~clk;

  syscall_read_string dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sys       (sys),
    .regv      (regv),
    .rega      (rega),
    .regb      (regb),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .busy      (busy),
    .done      (done)
  );

  int unsigned  total = 0, bad = 0;
  logic [63:0]  exp_q[$];
  int unsigned  exp_done = 0, seen_done = 0;
  byte unsigned stim[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Monitor: every write and done pulse is matched against the scoreboard.
  initial forever begin
    @(posedge clk); #1;
    if (rst_n) begin
      if (mem_we) begin
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_write: got %h at %h want none", mem_wdata, mem_addr);
        end else begin
          chk("write", {mem_addr, mem_wdata}, exp_q.pop_front());
        end
      end
      if (done) begin
        seen_done++;
        if (seen_done > exp_done) begin
          total++; bad++;
          $display("FAIL unexpected_done: got %0d pulses want %0d", seen_done, exp_done);
        end
      end
    end
  end

  task automatic load(input string s);
    stim.delete();
    for (int i = 0; i < s.len(); i++) stim.push_back(s[i]);
  endtask

  // Reference: what the service stores is the string up to newline or length-1
  // characters, plus zero terminator, laid out little-endian in whole words.
  task automatic model(input logic [31:0] a, input logic [31:0] l, output int unsigned consumed);
    byte unsigned chars[$];
    logic [31:0]  w;
    int unsigned  nw;
    consumed = 0;
    if (l >= 2) begin
      for (int i = 0; i < stim.size(); i++) begin
        consumed++;
        if (stim[i] == 8'h0A) break;
        chars.push_back(stim[i]);
        if (chars.size() == int'(l) - 1) break;
      end
    end
    if (l != 0) begin
      nw = chars.size() / 4 + 1;
      for (int unsigned k = 0; k < nw; k++) begin
        w = '0;
        for (int unsigned j = 0; j < 4; j++)
          if (4 * k + j < chars.size()) w[8*j +: 8] = chars[4*k+j];
        exp_q.push_back({a + k, w});
      end
    end
    exp_done++;
  endtask

  task automatic run_txn(input logic [31:0] a, input logic [31:0] l, input bit poke);
    int unsigned want, idx, cyc, target;
    idx = 0; cyc = 0;
    model(a, l, want);
    target = exp_done;
    @(negedge clk);
    sys = 1'b1; regv = SYS_READ_STRING; rega = a; regb = l;
    @(negedge clk);
    sys = 1'b0; rega = $urandom; regb = $urandom; regv = $urandom_range(0, 15);
    while (seen_done < target && cyc < 400) begin
      if (idx < stim.size()) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_data  = stim[idx];
      end else begin
        in_valid = 1'b0;
        in_data  = 8'($urandom);
      end
      if (poke && cyc == 3 && busy) begin
        sys = 1'b1; regv = SYS_READ_STRING; rega = 32'h0000_0BAD; regb = 32'd0;
      end else begin
        sys = 1'b0;
      end
      if (in_valid && in_ready) idx++;
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0; sys = 1'b0;
    chk("done_count", 64'(seen_done), 64'(target));
    chk("bytes_consumed", 64'(idx), 64'(want));
    repeat (2) @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_in_ready"},  64'(in_ready),  64'd0);
    chk({tag, "_mem_we"},    64'(mem_we),    64'd0);
    chk({tag, "_busy"},      64'(busy),      64'd0);
    chk({tag, "_done"},      64'(done),      64'd0);
    chk({tag, "_mem_addr"},  64'(mem_addr),  64'd0);
    chk({tag, "_mem_wdata"}, 64'(mem_wdata), 64'd0);
  endtask

  initial begin
    int unsigned idx, cyc, slen;
    string       s;
    rst_n = 1'b0; sys = 1'b0; regv = '0; rega = '0; regb = '0;
    in_valid = 1'b0; in_data = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    load("Hi\n");     run_txn(32'h0040_0010, 32'd16, 1'b0);
    load("abcd\n");   run_txn(32'h0040_0020, 32'd16, 1'b0);
    load("abcdefg");  run_txn(32'h0040_0030, 32'd5,  1'b0);
    load("x\n");      run_txn(32'h0040_0040, 32'd0,  1'b0);
    load("x\n");      run_txn(32'h0040_0050, 32'd1,  1'b0);

    // Wrong service code: nothing may start.
    @(negedge clk); sys = 1'b1; regv = SYS_PRINT_STRING; regb = 32'd16;
    @(negedge clk); sys = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("busy_regv4", 64'(busy), 64'd0);
      @(negedge clk);
    end

    load("hello world\n"); run_txn(32'h0040_0060, 32'd32, 1'b1);

    // Abort mid-receive with reset, then a clean run.
    load("abcdefgh\n");
    @(negedge clk); sys = 1'b1; regv = SYS_READ_STRING; rega = 32'h0000_0100; regb = 32'd16;
    @(negedge clk); sys = 1'b0;
    idx = 0; cyc = 0;
    while (idx < 2 && cyc < 50) begin
      in_valid = 1'b1; in_data = stim[idx];
      if (in_ready) idx++;
      @(negedge clk);
      cyc++;
    end
    chk("abort_bytes", 64'(idx), 64'd2);
    in_valid = 1'b0; rst_n = 1'b0;
    #1;
    check_reset_outputs("abort");
    @(negedge clk);
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(negedge clk);
    load("ok\n"); run_txn(32'h0000_0200, 32'd8, 1'b0);

    for (int t = 0; t < 12; t++) begin
      slen = $urandom_range(0, 14);
      stim.delete();
      for (int unsigned i = 0; i < slen; i++)
        stim.push_back(($urandom_range(0, 9) == 0) ? 8'h0A : 8'($urandom_range(32, 126)));
      stim.push_back(8'h0A);
      run_txn($urandom, $urandom_range(0, 12), t[0]);
    end

    chk("leftover_writes", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
